uart_clkgen: RTL

//  - Parametrised successor to the UART clock block. Generates NUM_CH independent baud-rate

---
 rtl/uart_clkgen_pkg.sv | 21 ++
 rtl/uart_clkgen_ch.sv | 44 ++++
 rtl/uart_clkgen.sv | 93 +++++++++
 3 files changed

// File: rtl/uart_clkgen_pkg.sv
// Shared constants, the pending-update record and the divider clamp for uart_clkgen.
package uart_clkgen_pkg;

    localparam int MIN_DIV            = 2;
    localparam int CLKGEN_DEFAULT_DIV = 434;   // 50 MHz / 115200
    localparam int CFG_CH_MAX_W       = 8;
    localparam int CFG_DIV_MAX_W      = 32;

    typedef logic [CFG_DIV_MAX_W-1:0] div_t;

    typedef struct packed {
        logic [CFG_CH_MAX_W-1:0] ch;
        div_t                    div;
    } cfg_t;

    // Divide ratios 0 and 1 cannot produce a tick/square-wave pair.
    function automatic div_t clamp_div(input div_t d);
        return (d < div_t'(MIN_DIV)) ? div_t'(MIN_DIV) : d;
    endfunction

endpackage

// File: rtl/uart_clkgen_ch.sv
// One baud channel: counter, committed divider, registered tick and square-wave decode.
module uart_clkgen_ch #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 434
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             apply,
    input  logic [DIV_W-1:0] new_div,
    output logic             tick,
    output logic             clk_div,
    output logic             term
);
    import uart_clkgen_pkg::*;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    assign term = (cnt_q == div_q - DIV_W'(1));

    // New divider only lands on a period boundary, so no period is cut short or stretched.
    always_comb begin
        cnt_d  = term ? '0 : cnt_q + DIV_W'(1);
        div_d  = (term && apply) ? new_div : div_q;
        tick_d = term;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            div_q  <= DIV_W'(DEFAULT_DIV);
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick    = tick_q;
    assign clk_div = (cnt_q < (div_q >> 1));

endmodule

// File: rtl/uart_clkgen.sv
// Multi-channel baud tick generator with a single-slot runtime divider update port and lock flag.
module uart_clkgen #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 4,
    parameter int DEFAULT_DIV = uart_clkgen_pkg::CLKGEN_DEFAULT_DIV,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              inclk0,
    input  logic              areset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_div,
    output logic              locked
);
    import uart_clkgen_pkg::*;

    localparam int LCNT_W = $clog2(LOCK_CYCLES + 1);

    cfg_t              pend_q, pend_d;
    logic              pending_q, pending_d;
    logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;

    logic [NUM_CH-1:0] apply, term;
    logic              accept, ch_ok, take, applying;
    logic              unused_div_hi;

    assign cfg_ready = !pending_q;
    assign accept    = cfg_valid && cfg_ready;
    assign ch_ok     = (int'(cfg_ch) < NUM_CH);
    assign take      = accept && ch_ok;
    assign applying  = |(apply & term);

    // Bits of the record above DIV_W are always zero.
    assign unused_div_hi = |(pend_q.div >> DIV_W);

    always_comb begin
        pend_d     = pend_q;
        pending_d  = pending_q;
        lock_cnt_d = lock_cnt_q;
        if (take) begin
            pending_d  = 1'b1;
            pend_d.ch  = CFG_CH_MAX_W'(cfg_ch);
            pend_d.div = clamp_div(div_t'(cfg_div));
        end else if (applying) begin
            pending_d = 1'b0;
        end
        // Pending still set on the application edge, so counting restarts the edge after.
        if (take || pending_q)
            lock_cnt_d = '0;
        else if (lock_cnt_q != LCNT_W'(LOCK_CYCLES))
            lock_cnt_d = lock_cnt_q + LCNT_W'(1);
        locked_d = (lock_cnt_d == LCNT_W'(LOCK_CYCLES));
    end

    always_ff @(posedge inclk0 or negedge areset_n) begin
        if (!areset_n) begin
            pend_q     <= '0;
            pending_q  <= 1'b0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pending_q  <= pending_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign locked = locked_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign apply[i] = pending_q && (pend_q.ch == CFG_CH_MAX_W'(i));

        uart_clkgen_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (inclk0),
            .rst_n   (areset_n),
            .apply   (apply[i]),
            .new_div (DIV_W'(pend_q.div)),
            .tick    (tick[i]),
            .clk_div (clk_div[i]),
            .term    (term[i])
        );
    end

endmodule
